// File: rtl/mpsoc_ahb3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mpsoc_ahb3_pkg                                                             |
// | AHB3-Lite encodings, SRAM slave FSM state type and byte-lane helper.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mpsoc_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Byte-lane mask for a transfer of 2**size bytes; misaligned offsets are
  // aligned down so the mask always stays inside one naturally aligned unit.
  function automatic logic [7:0] be_gen(input logic [2:0] size, input logic [2:0] lo);
    logic [3:0]  nbytes;
    logic [2:0]  base;
    logic [15:0] mask;
    nbytes = 4'd1 << size[1:0];
    base   = lo & ~(3'(nbytes - 4'd1));
    mask   = ((16'd1 << nbytes) - 16'd1) << base;
    return mask[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpsoc_spram_be.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mpsoc_spram_be                                                             |
// | Single-port byte-enabled RAM, asynchronous read, synchronous write.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mpsoc_spram_be #(
  parameter int DEPTH = 256,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic [AW-1:0]   i_addr,
  input  logic            i_we,
  input  logic [DW/8-1:0] i_be,
  input  logic [DW-1:0]   i_din,
  output logic [DW-1:0]   o_dout
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < DW/8; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_din[8*i +: 8];
      end
    end
  end

  assign o_dout = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/mpsoc_ahb3_spram_ws.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mpsoc_ahb3_spram_ws                                                        |
// | AHB3-Lite SRAM slave with configurable wait states and write forwarding.  |
// | Optional macro AHB3_SPRAM_ERR_EN enables ERROR responses for bad transfers.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mpsoc_ahb3_spram_ws
  import mpsoc_ahb3_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int PLEN        = 32,
  parameter int XLEN        = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP
);

  localparam int         c_BE_W     = XLEN/8;
  localparam int         c_BA_W     = $clog2(c_BE_W);
  localparam int         c_AW       = $clog2(MEM_DEPTH);
  localparam logic [2:0] c_MAX_SIZE = 3'(c_BA_W);
  localparam logic [2:0] c_CNT_INIT = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic              r_hreadyout;
  logic              r_hresp;
  logic              r_dp_valid;
  logic              r_dp_write;
  logic [c_AW-1:0]   r_dp_addr;
  logic [c_BE_W-1:0] r_dp_be;
  logic [XLEN-1:0]   r_hrdata;

  logic              r_pw_valid;
  logic [c_AW-1:0]   r_pw_addr;
  logic [c_BE_W-1:0] r_pw_be;
  logic [XLEN-1:0]   r_pw_data;

  logic              w_accept;
  logic              w_err;
  logic [2:0]        w_size_eff;
  logic [7:0]        w_be_full;
  logic [c_BE_W-1:0] w_be_new;
  logic [c_AW-1:0]   w_word;
  logic              w_commit;
  logic              w_rd_load;
  logic [c_AW-1:0]   w_rd_addr;
  logic [c_AW-1:0]   w_ram_addr;
  logic              w_ram_we;
  logic [XLEN-1:0]   w_ram_dout;
  logic [XLEN-1:0]   w_rd_merged;
  logic              w_unused;

  assign w_accept   = HSEL & HREADY & HTRANS[1] & ((r_state == ST_IDLE) | (r_state == ST_ERR2));
  assign w_size_eff = (HSIZE > c_MAX_SIZE) ? c_MAX_SIZE : HSIZE;
  assign w_be_full  = be_gen(w_size_eff, 3'(HADDR[c_BA_W-1:0]));
  assign w_be_new   = w_be_full[c_BE_W-1:0];
  assign w_word     = HADDR[c_BA_W+c_AW-1:c_BA_W];

`ifdef AHB3_SPRAM_ERR_EN
  localparam logic [63:0] c_LIMIT = 64'(MEM_DEPTH) * 64'(c_BE_W);
  logic [2:0] w_align_mask;
  assign w_align_mask = 3'((4'd1 << HSIZE[1:0]) - 4'd1);
  assign w_err = (HSIZE > c_MAX_SIZE) | (|(HADDR[2:0] & w_align_mask)) | (64'(HADDR) >= c_LIMIT);
  assign HRESP = r_hresp;
  assign w_unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR, w_be_full};
`else
  assign w_err = 1'b0;
  assign HRESP = 1'b0;
  assign w_unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR, w_be_full, r_hresp};
`endif

  assign HREADYOUT = r_hreadyout;
  assign HRDATA    = r_hrdata;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_dp_valid  <= 1'b0;
      r_dp_write  <= 1'b0;
      r_dp_addr   <= '0;
      r_dp_be     <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERR2: begin
          r_state     <= ST_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
          r_dp_valid  <= 1'b0;
          if (w_accept) begin
            if (w_err) begin
              r_state     <= ST_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end else begin
              r_dp_valid <= 1'b1;
              r_dp_write <= HWRITE;
              r_dp_addr  <= w_word;
              r_dp_be    <= w_be_new;
              if (WAIT_STATES > 0) begin
                r_state     <= ST_WAIT;
                r_hreadyout <= 1'b0;
                r_cnt       <= c_CNT_INIT;
              end
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read data is loaded at the edge that opens the final data-phase cycle.
  always_comb begin
    w_rd_load = 1'b0;
    w_rd_addr = r_dp_addr;
    if (!HRESET) begin
      if (WAIT_STATES == 0) begin
        w_rd_load = w_accept & ~w_err & ~HWRITE;
        w_rd_addr = w_word;
      end else begin
        w_rd_load = (r_state == ST_WAIT) & (r_cnt == 3'd0) & r_dp_valid & ~r_dp_write;
      end
    end
  end

  assign w_commit = (r_state == ST_IDLE) & r_dp_valid & r_dp_write & ~HRESET;

  // Committed writes park in a one-entry buffer and drain whenever the port is not reading.
  assign w_ram_addr = w_rd_load ? w_rd_addr : r_pw_addr;
  assign w_ram_we   = r_pw_valid & ~w_rd_load;

  always_comb begin
    w_rd_merged = w_ram_dout;
    for (int i = 0; i < c_BE_W; i++) begin
      if (r_pw_valid && (r_pw_addr == w_rd_addr) && r_pw_be[i])
        w_rd_merged[8*i +: 8] = r_pw_data[8*i +: 8];
      if (w_commit && (r_dp_addr == w_rd_addr) && r_dp_be[i])
        w_rd_merged[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_hrdata   <= '0;
      r_pw_valid <= 1'b0;
    end else begin
      if (w_rd_load) r_hrdata <= w_rd_merged;
      if (w_commit) begin
        r_pw_valid <= 1'b1;
        r_pw_addr  <= r_dp_addr;
        r_pw_be    <= r_dp_be;
        r_pw_data  <= HWDATA;
      end else if (!w_rd_load) begin
        r_pw_valid <= 1'b0;
      end
    end
  end

  mpsoc_spram_be #(
    .DEPTH (MEM_DEPTH),
    .DW    (XLEN),
    .AW    (c_AW)
  ) u_ram (
    .i_clk  (HCLK),
    .i_addr (w_ram_addr),
    .i_we   (w_ram_we),
    .i_be   (r_pw_be),
    .i_din  (r_pw_data),
    .o_dout (w_ram_dout)
  );

endmodule
`default_nettype wire

// File: tb/tb_mpsoc_ahb3_spram_ws.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mpsoc_ahb3_spram_ws                                                     |
// | Directed bench: one slave with no wait states, one with three.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mpsoc_ahb3_spram_ws;

  logic        clk = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hburst = '0;
  logic [3:0]  hprot = '0;
  logic        hmastlock = 1'b0;
  logic        sel = 1'b0;

  logic [31:0] rdata0, rdata3;
  logic        ready0, ready3, resp0, resp3;
  logic [31:0] rdata_m;
  logic        ready_m, resp_m;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  int          lc;
  logic        fr, fp, lp;

  always #5 clk = ~clk;

  assign rdata_m = sel ? rdata3 : rdata0;
  assign ready_m = sel ? ready3 : ready0;
  assign resp_m  = sel ? resp3  : resp0;

  mpsoc_ahb3_spram_ws #(.MEM_DEPTH(256), .PLEN(32), .XLEN(32), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel & ~sel), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(ready0), .HREADYOUT(ready0), .HRESP(resp0)
  );

  mpsoc_ahb3_spram_ws #(.MEM_DEPTH(256), .PLEN(32), .XLEN(32), .WAIT_STATES(3)) u_dut3 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel & sel), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata3), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(ready3), .HREADYOUT(ready3), .HRESP(resp3)
  );

  // Single transfer; returns once the final data-phase cycle is observed.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] size, output logic [31:0] rdat, output int lowcnt,
                      output logic first_rdy, output logic first_resp, output logic last_resp);
    int n;
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
    lowcnt = 0; n = 0;
    @(negedge clk);
    first_rdy = ready_m; first_resp = resp_m;
    while (ready_m !== 1'b1 && n < 20) begin
      lowcnt++; n++;
      @(negedge clk);
    end
    last_resp = resp_m;
    rdat = rdata_m;
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL xfer_timeout: HREADYOUT still %b after %0d cycles, required 1", ready_m, n);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b expected 1", ready0); end
    checks++; if (resp0 !== 1'b0) begin errors++; $display("FAIL reset_resp0: got %b expected 0", resp0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h expected 0", rdata0); end
    checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL reset_ready3: got %b expected 1", ready3); end
    checks++; if (resp3 !== 1'b0) begin errors++; $display("FAIL reset_resp3: got %b expected 0", resp3); end
    checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL reset_rdata3: got %h expected 0", rdata3); end
    @(posedge clk); #1;
    hreset = 1'b0;
  endtask

  task automatic test_ws0;
    sel = 1'b0;
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, rd, lc, fr, fp, lp);
    checks++; if (lc !== 0) begin errors++; $display("FAIL ws0_wr_low: got %0d expected 0", lc); end
    checks++; if (lp !== 1'b0) begin errors++; $display("FAIL ws0_wr_resp: got %b expected 0", lp); end
    xfer(1'b0, 32'h10, 32'h0, 3'd2, rd, lc, fr, fp, lp);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ws0_rd_data: got %h expected deadbeef", rd); end
    checks++; if (lc !== 0) begin errors++; $display("FAIL ws0_rd_low: got %0d expected 0", lc); end
    checks++; if (lp !== 1'b0) begin errors++; $display("FAIL ws0_rd_resp: got %b expected 0", lp); end
  endtask

  task automatic test_ws3;
    sel = 1'b1;
    xfer(1'b1, 32'h44, 32'hCAFEF00D, 3'd2, rd, lc, fr, fp, lp);
    checks++; if (lc !== 3) begin errors++; $display("FAIL ws3_wr_low: got %0d expected 3", lc); end
    xfer(1'b0, 32'h44, 32'h0, 3'd2, rd, lc, fr, fp, lp);
    checks++; if (lc !== 3) begin errors++; $display("FAIL ws3_rd_low: got %0d expected 3", lc); end
    checks++; if (fr !== 1'b0) begin errors++; $display("FAIL ws3_rd_first_ready: got %b expected 0", fr); end
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL ws3_rd_data: got %h expected cafef00d", rd); end
    xfer(1'b1, 32'h46, 32'hBEEF1234, 3'd1, rd, lc, fr, fp, lp);
    xfer(1'b0, 32'h44, 32'h0, 3'd2, rd, lc, fr, fp, lp);
    checks++; if (rd !== 32'hBEEFF00D) begin errors++; $display("FAIL ws3_hword_merge: got %h expected beeff00d", rd); end
  endtask

  task automatic test_back_to_back;
    sel = 1'b0;
    xfer(1'b1, 32'h10, 32'h11223344, 3'd2, rd, lc, fr, fp, lp);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h13; hwrite = 1'b1; hsize = 3'd0;
    @(posedge clk); #1;
    haddr = 32'h10; hwrite = 1'b0; hsize = 3'd2; hwdata = 32'hAA555555;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", ready0); end
    checks++; if (rdata0 !== 32'hAA223344) begin errors++; $display("FAIL b2b_forward: got %h expected aa223344", rdata0); end
    xfer(1'b0, 32'h10, 32'h0, 3'd2, rd, lc, fr, fp, lp);
    checks++; if (rd !== 32'hAA223344) begin errors++; $display("FAIL b2b_stored: got %h expected aa223344", rd); end
  endtask

  task automatic test_errors;
    sel = 1'b0;
    xfer(1'b1, 32'h0, 32'h12345678, 3'd2, rd, lc, fr, fp, lp);
    xfer(1'b1, 32'h8, 32'h01020304, 3'd2, rd, lc, fr, fp, lp);
`ifdef AHB3_SPRAM_ERR_EN
    xfer(1'b1, 32'h400, 32'hFFFFFFFF, 3'd2, rd, lc, fr, fp, lp);
    checks++; if (fr !== 1'b0) begin errors++; $display("FAIL err1_ready: got %b expected 0", fr); end
    checks++; if (fp !== 1'b1) begin errors++; $display("FAIL err1_resp: got %b expected 1", fp); end
    checks++; if (lp !== 1'b1) begin errors++; $display("FAIL err2_resp: got %b expected 1", lp); end
    checks++; if (lc !== 1) begin errors++; $display("FAIL err_low: got %0d expected 1", lc); end
    xfer(1'b0, 32'h0, 32'h0, 3'd2, rd, lc, fr, fp, lp);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL err_no_write: got %h expected 12345678", rd); end
    checks++; if (lp !== 1'b0) begin errors++; $display("FAIL err_ok_after: got %b expected 0", lp); end
    xfer(1'b1, 32'h1, 32'hFFFFFFFF, 3'd1, rd, lc, fr, fp, lp);
    checks++; if (fp !== 1'b1 || lp !== 1'b1) begin errors++; $display("FAIL err_misalign: got %b%b expected 11", fp, lp); end
    xfer(1'b0, 32'h0, 32'h0, 3'd3, rd, lc, fr, fp, lp);
    checks++; if (fp !== 1'b1 || lp !== 1'b1) begin errors++; $display("FAIL err_oversize: got %b%b expected 11", fp, lp); end
    xfer(1'b0, 32'h8, 32'h0, 3'd2, rd, lc, fr, fp, lp);
    checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL err_misalign_nowr: got %h expected 01020304", rd); end
`else
    xfer(1'b1, 32'h400, 32'hA5A5A5A5, 3'd2, rd, lc, fr, fp, lp);
    checks++; if (lp !== 1'b0 || lc !== 0) begin errors++; $display("FAIL wrap_resp: got resp %b low %0d expected 0 0", lp, lc); end
    xfer(1'b0, 32'h0, 32'h0, 3'd2, rd, lc, fr, fp, lp);
    checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap_word0: got %h expected a5a5a5a5", rd); end
    xfer(1'b1, 32'hC, 32'hCAFE0001, 3'd3, rd, lc, fr, fp, lp);
    xfer(1'b0, 32'hC, 32'h0, 3'd2, rd, lc, fr, fp, lp);
    checks++; if (rd !== 32'hCAFE0001) begin errors++; $display("FAIL oversize_full: got %h expected cafe0001", rd); end
    xfer(1'b1, 32'h9, 32'hFFFF1357, 3'd1, rd, lc, fr, fp, lp);
    xfer(1'b0, 32'h8, 32'h0, 3'd2, rd, lc, fr, fp, lp);
    checks++; if (rd !== 32'h01021357) begin errors++; $display("FAIL misalign_down: got %h expected 01021357", rd); end
    checks++; if (lp !== 1'b0) begin errors++; $display("FAIL noerr_resp: got %b expected 0", lp); end
`endif
  endtask

  task automatic test_reset_mid_wait;
    sel = 1'b1;
    xfer(1'b1, 32'h20, 32'h11111111, 3'd2, rd, lc, fr, fp, lp);
    xfer(1'b0, 32'h20, 32'h0, 3'd2, rd, lc, fr, fp, lp);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL rstw_pre: got %h expected 11111111", rd); end
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h99999999;
    @(posedge clk); #1;
    hreset = 1'b1;
    @(negedge clk);
    checks++; if (ready3 !== 1'b0) begin errors++; $display("FAIL rstw_in_wait: got %b expected 0", ready3); end
    @(posedge clk); #1;
    hreset = 1'b0;
    @(negedge clk);
    checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL rstw_ready: got %b expected 1", ready3); end
    checks++; if (resp3 !== 1'b0) begin errors++; $display("FAIL rstw_resp: got %b expected 0", resp3); end
    checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL rstw_rdata: got %h expected 0", rdata3); end
    xfer(1'b0, 32'h20, 32'h0, 3'd2, rd, lc, fr, fp, lp);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL rstw_unchanged: got %h expected 11111111", rd); end
  endtask

  initial begin
    test_reset;
    test_ws0;
    test_ws3;
    test_back_to_back;
    test_errors;
    test_reset_mid_wait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
